// File: rtl/password_enroll.sv
// ---------------------------------------------------------------------------
// PasswordEnroll (module password_enroll)
//
// Purpose:
//   Writer side of the switch-entered 4-digit lock. After a start pulse the
//   user keys in four digits, then the same four digits again. When both
//   passes agree, the code is committed to o_code_out, which feeds the
//   checker's reference code. A bad key event, a mismatch or an idle timeout
//   ends the attempt in ERROR.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst_a_n       asynchronous active-low reset
//   i_start         one-cycle pulse, begins or restarts enrollment
//   i_digit_pulse   one-hot digit pulses, bit i = digit i pressed
//   o_code_out      committed code, 4 BCD nibbles, first digit in [3:0]
//   o_code_valid    one-cycle pulse when o_code_out takes a new value
//   o_disp_state    0 idle, 1 error, 2 done, 3 in process
//   o_digit_count   digits accepted in the current pass, 0..4
//   o_busy          high while either entry pass is in progress
// ---------------------------------------------------------------------------
module password_enroll #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h6102,
  parameter int          TIMEOUT_CYCLES = 50_000_000,
  parameter int          TW             = 26
) (
  input  logic        i_clk,
  input  logic        i_rst_a_n,
  input  logic        i_start,
  input  logic [9:0]  i_digit_pulse,
  output logic [15:0] o_code_out,
  output logic        o_code_valid,
  output logic [1:0]  o_disp_state,
  output logic [2:0]  o_digit_count,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTER1 = 3'd1,
    ENTER2 = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        r_state,     w_stateNext;
  logic [15:0]   r_shadow,    w_shadowNext;
  logic [2:0]    r_count,     w_countNext;
  logic [TW-1:0] r_timer,     w_timerNext;
  logic          r_mismatch,  w_mismatchNext;
  logic [15:0]   r_code,      w_codeNext;
  logic          r_codeValid, w_codeValidNext;
  logic [1:0]    r_disp,      w_dispNext;
  logic          r_busy,      w_busyNext;

  logic          w_anyPulse;
  logic          w_oneHot;
  logic          w_invalid;
  logic [3:0]    w_digit;
  logic [3:0]    w_shadowNibble;

  // Classify the digit pulses: a single set bit is a real key press, any
  // multi-bit pattern (two switches bouncing together) is an invalid event.
  always_comb begin
    w_anyPulse = (i_digit_pulse != 10'd0);
    w_oneHot   = w_anyPulse && ((i_digit_pulse & (i_digit_pulse - 10'd1)) == 10'd0);
    w_invalid  = w_anyPulse && !w_oneHot;
    w_digit    = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (i_digit_pulse[i]) begin
        w_digit = 4'(i);
      end
    end
  end

  // The nibble of the first pass that lines up with the digit being entered.
  assign w_shadowNibble = r_shadow[{r_count[1:0], 2'b00} +: 4];

  // Next-state logic. Within the entry passes start has top priority, then
  // an invalid event, then a valid digit, and only a cycle with no pulse at
  // all can time out. Mismatches in the second pass are accumulated so the
  // verdict is only given after the fourth digit.
  always_comb begin
    w_stateNext     = r_state;
    w_shadowNext    = r_shadow;
    w_countNext     = r_count;
    w_timerNext     = r_timer;
    w_mismatchNext  = r_mismatch;
    w_codeNext      = r_code;
    w_codeValidNext = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_stateNext    = ENTER1;
          w_shadowNext   = 16'd0;
          w_countNext    = 3'd0;
          w_timerNext    = '0;
          w_mismatchNext = 1'b0;
        end
      end

      ENTER1, ENTER2: begin
        if (i_start) begin
          w_stateNext    = ENTER1;
          w_shadowNext   = 16'd0;
          w_countNext    = 3'd0;
          w_timerNext    = '0;
          w_mismatchNext = 1'b0;
        end else if (w_invalid) begin
          w_stateNext = ERROR;
          w_countNext = 3'd0;
        end else if (w_oneHot) begin
          w_timerNext = '0;
          if (r_state == ENTER1) begin
            w_shadowNext[{r_count[1:0], 2'b00} +: 4] = w_digit;
            if (r_count == 3'd3) begin
              w_stateNext    = ENTER2;
              w_countNext    = 3'd0;
              w_mismatchNext = 1'b0;
            end else begin
              w_countNext = r_count + 3'd1;
            end
          end else begin
            if (r_count == 3'd3) begin
              w_countNext = 3'd0;
              if (!r_mismatch && (w_digit == w_shadowNibble)) begin
                w_stateNext     = DONE;
                w_codeNext      = r_shadow;
                w_codeValidNext = 1'b1;
              end else begin
                w_stateNext = ERROR;
              end
            end else begin
              w_countNext    = r_count + 3'd1;
              w_mismatchNext = r_mismatch | (w_digit != w_shadowNibble);
            end
          end
        end else if (r_timer == TIMER_LAST) begin
          w_stateNext = ERROR;
          w_countNext = 3'd0;
        end else begin
          w_timerNext = r_timer + 1'b1;
        end
      end

      DONE, ERROR: begin
        if (i_start) begin
          w_stateNext    = ENTER1;
          w_shadowNext   = 16'd0;
          w_countNext    = 3'd0;
          w_timerNext    = '0;
          w_mismatchNext = 1'b0;
        end else if (w_anyPulse) begin
          w_stateNext = IDLE;
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_countNext = 3'd0;
      end
    endcase
  end

  // Display and busy flags are decoded from the next state so the registered
  // outputs show the state being entered on the same edge.
  always_comb begin
    w_dispNext = 2'd0;
    w_busyNext = 1'b0;
    case (w_stateNext)
      ERROR:          w_dispNext = 2'd1;
      DONE:           w_dispNext = 2'd2;
      ENTER1, ENTER2: begin
        w_dispNext = 2'd3;
        w_busyNext = 1'b1;
      end
      default:        w_dispNext = 2'd0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_a_n) begin
    if (!i_rst_a_n) begin
      r_state     <= IDLE;
      r_shadow    <= 16'd0;
      r_count     <= 3'd0;
      r_timer     <= '0;
      r_mismatch  <= 1'b0;
      r_code      <= DEFAULT_CODE;
      r_codeValid <= 1'b0;
      r_disp      <= 2'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_shadow    <= w_shadowNext;
      r_count     <= w_countNext;
      r_timer     <= w_timerNext;
      r_mismatch  <= w_mismatchNext;
      r_code      <= w_codeNext;
      r_codeValid <= w_codeValidNext;
      r_disp      <= w_dispNext;
      r_busy      <= w_busyNext;
    end
  end

  assign o_code_out    = r_code;
  assign o_code_valid  = r_codeValid;
  assign o_disp_state  = r_disp;
  assign o_digit_count = r_count;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_password_enroll.sv
// ---------------------------------------------------------------------------
// Bench for password_enroll. Expected commits are queued by the stimulus
// process; a monitor pops one each time the DUT raises o_code_valid.
// Status outputs are checked at fixed points in the stimulus sequence.
// ---------------------------------------------------------------------------
module tb_password_enroll;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  digitPulse = 10'd0;
  logic [15:0] codeOut;
  logic        codeValid;
  logic [1:0]  dispState;
  logic [2:0]  digitCount;
  logic        busy;

  int testsRun = 0;
  int testsFailed = 0;

  logic [15:0] expectedQ[$];
  logic [15:0] modelCode;

  password_enroll #(
    .DEFAULT_CODE  (16'h6102),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TW            (5)
  ) dut (
    .i_clk        (clk),
    .i_rst_a_n    (rstN),
    .i_start      (start),
    .i_digit_pulse(digitPulse),
    .o_code_out   (codeOut),
    .o_code_valid (codeValid),
    .o_disp_state (dispState),
    .o_digit_count(digitCount),
    .o_busy       (busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard limit so the bench can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every commit pulse must match the oldest queued code.
  always @(negedge clk) begin
    if (codeValid === 1'b1) begin
      if (expectedQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_commit: got code %h, expected no commit", codeOut);
      end else begin
        checkOutput("commit_code", codeOut, expectedQ.pop_front());
      end
    end
  end

  // Drive one cycle of inputs, then leave the bench at posedge+1.
  task automatic applyStimulus(input logic s, input logic [9:0] p);
    start      = s;
    digitPulse = p;
    @(posedge clk);
    #1;
    start      = 1'b0;
    digitPulse = 10'd0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [9:0] oneHot(input int d);
    logic [9:0] v;
    v = 10'd1 << d;
    return v;
  endfunction

  task automatic pressDigit(input int d);
    applyStimulus(1'b0, oneHot(d));
  endtask

  // Reference model: an enrollment of two complete passes commits the first
  // pass, packed first digit lowest, only when the passes are identical.
  function automatic logic [15:0] packCode(input int d[4]);
    logic [15:0] c;
    c = 16'd0;
    for (int k = 0; k < 4; k++) c[k*4 +: 4] = 4'(d[k]);
    return c;
  endfunction

  task automatic runSession(input int p1[4], input int p2[4], input int maxGap);
    logic match;
    match = (p1 == p2);
    applyStimulus(1'b1, 10'd0);
    for (int k = 0; k < 4; k++) begin
      idleCycles($urandom_range(maxGap, 0));
      pressDigit(p1[k]);
    end
    for (int k = 0; k < 4; k++) begin
      idleCycles($urandom_range(maxGap, 0));
      if (k == 3 && match) expectedQ.push_back(packCode(p1));
      pressDigit(p2[k]);
    end
    if (match) modelCode = packCode(p1);
    checkOutput("session_disp", {14'd0, dispState}, match ? 16'd2 : 16'd1);
    checkOutput("session_code", codeOut, modelCode);
  endtask

  initial begin
    int a[4];
    int b[4];

    modelCode = 16'h6102;
    idleCycles(3);
    rstN = 1'b1;
    idleCycles(1);

    // Reset state and quiet idle period.
    checkOutput("reset_code", codeOut, 16'h6102);
    checkOutput("reset_disp", {14'd0, dispState}, 16'd0);
    checkOutput("reset_count", {13'd0, digitCount}, 16'd0);
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    idleCycles(100);
    checkOutput("idle_code", codeOut, 16'h6102);
    checkOutput("idle_disp", {14'd0, dispState}, 16'd0);

    // Digits in IDLE are ignored.
    pressDigit(4);
    checkOutput("idle_digit_ignored", {13'd0, digitCount}, 16'd0);

    // Matching enrollment 3,7,7,1.
    a = '{3, 7, 7, 1};
    applyStimulus(1'b1, 10'd0);
    checkOutput("start_disp", {14'd0, dispState}, 16'd3);
    checkOutput("start_busy", {15'd0, busy}, 16'd1);
    for (int k = 0; k < 3; k++) pressDigit(a[k]);
    checkOutput("pass1_count3", {13'd0, digitCount}, 16'd3);
    pressDigit(a[3]);
    checkOutput("pass2_entry_count", {13'd0, digitCount}, 16'd0);
    checkOutput("pass2_entry_busy", {15'd0, busy}, 16'd1);
    for (int k = 0; k < 3; k++) pressDigit(a[k]);
    expectedQ.push_back(16'h1773);
    pressDigit(a[3]);
    modelCode = 16'h1773;
    checkOutput("match_code", codeOut, 16'h1773);
    checkOutput("match_disp", {14'd0, dispState}, 16'd2);
    checkOutput("match_busy", {15'd0, busy}, 16'd0);
    idleCycles(2);

    // Mismatch on the last digit: 4,5,6,9 then 4,5,6,8.
    a = '{4, 5, 6, 9};
    b = '{4, 5, 6, 8};
    runSession(a, b, 0);
    pressDigit(0);
    checkOutput("error_to_idle", {14'd0, dispState}, 16'd0);

    // Invalid multi-bit event in the first pass, then restart.
    applyStimulus(1'b1, 10'd0);
    pressDigit(1);
    pressDigit(2);
    checkOutput("pre_invalid_count", {13'd0, digitCount}, 16'd2);
    applyStimulus(1'b0, 10'b0000000110);
    checkOutput("invalid_disp", {14'd0, dispState}, 16'd1);
    applyStimulus(1'b1, 10'd0);
    checkOutput("restart_disp", {14'd0, dispState}, 16'd3);
    checkOutput("restart_count", {13'd0, digitCount}, 16'd0);

    // Timeout: error lands on the TIMEOUT-th idle cycle after a digit.
    pressDigit(5);
    idleCycles(TIMEOUT - 1);
    checkOutput("timeout_not_yet", {14'd0, dispState}, 16'd3);
    idleCycles(1);
    checkOutput("timeout_error", {14'd0, dispState}, 16'd1);

    // Digit on the 15th cycle, then one on the very last allowed cycle.
    applyStimulus(1'b1, 10'd0);
    pressDigit(5);
    idleCycles(TIMEOUT - 2);
    pressDigit(6);
    checkOutput("digit_c15_disp", {14'd0, dispState}, 16'd3);
    checkOutput("digit_c15_count", {13'd0, digitCount}, 16'd2);
    idleCycles(TIMEOUT - 1);
    pressDigit(7);
    checkOutput("digit_c16_disp", {14'd0, dispState}, 16'd3);
    checkOutput("digit_c16_count", {13'd0, digitCount}, 16'd3);

    // Start and digit together mid second pass: digit is dropped.
    applyStimulus(1'b1, 10'd0);
    for (int k = 0; k < 4; k++) pressDigit(9);
    pressDigit(9);
    pressDigit(9);
    applyStimulus(1'b1, oneHot(5));
    checkOutput("prio_disp", {14'd0, dispState}, 16'd3);
    checkOutput("prio_count", {13'd0, digitCount}, 16'd0);
    a = '{1, 2, 3, 4};
    for (int k = 0; k < 4; k++) pressDigit(a[k]);
    for (int k = 0; k < 3; k++) pressDigit(a[k]);
    expectedQ.push_back(16'h4321);
    pressDigit(a[3]);
    modelCode = 16'h4321;
    checkOutput("prio_commit_code", codeOut, 16'h4321);

    // Asynchronous reset mid-entry, checked before the next clock edge.
    applyStimulus(1'b1, 10'd0);
    pressDigit(8);
    pressDigit(3);
    #2;
    rstN = 1'b0;
    #1;
    modelCode = 16'h6102;
    checkOutput("async_reset_code", codeOut, 16'h6102);
    checkOutput("async_reset_disp", {14'd0, dispState}, 16'd0);
    checkOutput("async_reset_count", {13'd0, digitCount}, 16'd0);
    checkOutput("async_reset_busy", {15'd0, busy}, 16'd0);
    idleCycles(3);
    rstN = 1'b1;
    idleCycles(1);

    // Randomized enrollments against the reference model.
    for (int s = 0; s < 24; s++) begin
      for (int k = 0; k < 4; k++) begin
        a[k] = int'($urandom_range(9, 0));
        b[k] = a[k];
      end
      if ($urandom_range(1, 0) == 1) begin
        int pos;
        pos = int'($urandom_range(3, 0));
        b[pos] = (a[pos] + int'($urandom_range(9, 1))) % 10;
      end
      runSession(a, b, 4);
      if ($urandom_range(2, 0) == 0) begin
        pressDigit(int'($urandom_range(9, 0)));
        checkOutput("rand_to_idle", {14'd0, dispState}, 16'd0);
      end
      idleCycles($urandom_range(3, 0));
    end

    idleCycles(4);
    checkOutput("final_code", codeOut, modelCode);
    checkOutput("queue_drained", 16'(expectedQ.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/password_enroll.md
Name: password_enroll

Overview:
- Writer side of the switch-entered 4-digit lock. The checker reads a stored code; this block captures, confirms and stores it.
- User asserts start, enters 4 digits, then re-enters the same 4 digits.
- On a match the block commits the code to code_out, which feeds the checker's reference code.
- Digit inputs are one-cycle one-hot pulses from the per-switch one-shot stage, exactly as the checker consumes them.

Parameters:
- DEFAULT_CODE, 16'h6102, code_out value after reset (digits 2,0,1,6 in entry order; digit 0 in [3:0]).
- TIMEOUT_CYCLES, 50_000_000, idle cycles allowed between digits before abort. Must be ≥ 2.
- TW, 26, width of the timeout counter. Must satisfy 2^TW ≥ TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_a_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins or restarts enrollment.
- digit_pulse  input  10  one-hot pulses; bit i high for one cycle = digit i pressed.
- code_out  output  16  committed code; 4 BCD nibbles, first-entered digit in [3:0].
- code_valid  output  1  one-cycle pulse on the cycle code_out takes a new value.
- disp_state  output  2  0 idle, 1 error, 2 done, 3 in process.
- digit_count  output  3  digits accepted in the current pass, 0..4.
- busy  output  1  high in ENTER1/ENTER2.

Behaviour:
- Reset (async assert, sync-safe release):
  - state = IDLE, code_out = DEFAULT_CODE, code_valid = 0, disp_state = 0, digit_count = 0, busy = 0.
  - Shadow buffer and timeout counter cleared.
  - Reset mid-enrollment discards the partial entry; code_out returns to DEFAULT_CODE.
- Input classification each cycle:
  - digit_pulse == 0: no event.
  - Exactly one bit set: valid digit, encoded to 4-bit value i (0..9).
  - More than one bit set: invalid event.
- Registered outputs: all outputs are registers. disp_state, busy and digit_count reflect the state entered on the same clock edge as the transition.
- States:
  - IDLE:
    - start -> ENTER1 with digit_count = 0.
    - Digit events ignored.
  - ENTER1:
    - Valid digit: written into shadow nibble [digit_count], digit_count + 1.
    - Fourth valid digit -> ENTER2 with digit_count = 0.
    - Invalid event -> ERROR.
  - ENTER2:
    - Valid digit: compared against shadow nibble [digit_count].
    - On the fourth digit with all four nibbles matching -> DONE; code_out <= shadow; code_valid = 1 for exactly that cycle.
    - Any mismatch at the fourth digit -> ERROR; code_out unchanged.
    - Mismatch is evaluated only at the fourth digit, so the user always enters 4 digits.
    - Invalid event -> ERROR.
  - DONE (disp 2) and ERROR (disp 1):
    - start -> ENTER1.
    - Any nonzero digit_pulse -> IDLE.
    - Otherwise hold.
- Timeout:
  - Counter clears on entry to ENTER1, on entry to ENTER2, and on every valid digit.
  - Counter increments on every other cycle in ENTER1/ENTER2.
  - When the counter equals TIMEOUT_CYCLES-1 with no event that cycle -> ERROR.
  - A digit arriving on that same cycle is accepted and clears the counter, so no timeout occurs.
- Priority:
  - start in ENTER1/ENTER2 restarts at ENTER1, digit_count = 0, shadow cleared, timeout cleared.
  - start wins over a simultaneous digit pulse, which is dropped.
  - start wins over a simultaneous timeout.
- Counting and width rules:
  - digit_count wraps only through state transitions; it never exceeds 4.
  - The displayed value 4 is never held: the fourth digit moves directly to the next state with digit_count = 0.
- code_out changes only on a successful commit or on reset.

Test Plan:
- Reset, then idle 100 cycles -> code_out = 16'h6102, disp_state = 0, code_valid never high.
- start; digits 3,7,7,1; digits 3,7,7,1 -> one code_valid pulse on the 8th digit edge, code_out = 16'h1773, disp_state = 2.
- start; digits 4,5,6,9; digits 4,5,6,8 -> disp_state = 1 after the 8th digit, code_out unchanged, no code_valid; then digit 0 -> disp_state = 0.
- start; digits 1,2, then digit_pulse = 10'b0000000110 -> ERROR, disp_state = 1; then start -> disp_state = 3, digit_count = 0.
- TIMEOUT_CYCLES = 16: start, one digit, wait 16 cycles -> ERROR on the 16th idle cycle. Repeat with the next digit on cycle 15 -> no error, digit_count = 2.
- Mid-ENTER2, assert start and digit 5 in the same cycle -> ENTER1, digit_count = 0, digit dropped. Then assert rst_a_n low mid-entry -> all outputs at reset values immediately, without waiting for a clock edge.
